// File: rtl/acc_feeder.sv
// Command-driven feeder for a fixed-function accelerator: stages an operand burst,
// replays it back-to-back, waits out the accelerator latency and buffers its results.
module acc_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_func,
  input  logic [4:0]            cmd_in_len,
  input  logic [4:0]            cmd_out_len,
  input  logic [7:0]            cmd_wait,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] acc_data_o,
  output logic                  acc_data_valid,
  output logic                  func_sel,
  input  logic [DATA_WIDTH-1:0] acc_out_i,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PRELOAD = 3'd1;
  localparam logic [2:0] S_SEND    = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;

  function automatic logic [CW-1:0] clamp_len(input logic [4:0] len);
    if (int'(len) > DEPTH) return CW'(DEPTH);
    return CW'(len);
  endfunction

  // State that follows the operand phase (or the accept itself when in_len is 0).
  function automatic logic [2:0] after_send(input logic [7:0] wt, input logic [CW-1:0] ol);
    if (wt != 8'd0) return S_WAIT;
    if (ol != '0)   return S_CAPTURE;
    return S_IDLE;
  endfunction

  function automatic logic [7:0] phase_cnt(input logic [7:0] wt, input logic [CW-1:0] ol);
    return (wt != 8'd0) ? wt : 8'(ol);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [2:0]            r_state;
  logic                  r_func;
  logic [CW-1:0]         r_in_len;
  logic [CW-1:0]         r_out_len;
  logic [7:0]            r_wait;
  logic [CW-1:0]         r_stage_cnt;
  logic [CW-1:0]         r_rd_idx;
  logic [7:0]            r_cnt;
  logic                  r_acc_vld;
  logic [DATA_WIDTH-1:0] r_acc_data;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_stage [DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo  [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic                  w_accept;
  logic [CW-1:0]         w_in_len;
  logic [CW-1:0]         w_out_len;
  logic [2:0]            w_post_cmd;
  logic [2:0]            w_post_send;
  logic                  w_s_fire;
  logic                  w_push;
  logic                  w_pop;

  assign cmd_ready   = !rst && (r_state == S_IDLE) && (r_count == '0);
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_in_len    = clamp_len(cmd_in_len);
  assign w_out_len   = clamp_len(cmd_out_len);
  assign w_post_cmd  = after_send(cmd_wait, w_out_len);
  assign w_post_send = after_send(r_wait, r_out_len);

  assign s_ready  = !rst && (r_state == S_PRELOAD) && (r_stage_cnt < r_in_len);
  assign w_s_fire = s_valid && s_ready;

  assign w_push = (r_state == S_CAPTURE);
  assign w_pop  = m_valid && m_ready;

  assign acc_data_o     = r_acc_data;
  assign acc_data_valid = r_acc_vld;
  assign func_sel       = r_func;
  assign busy           = (r_state != S_IDLE);
  assign done           = r_done;
  assign m_valid        = (r_count != '0);
  assign m_data         = r_fifo[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_func      <= 1'b0;
      r_in_len    <= '0;
      r_out_len   <= '0;
      r_wait      <= '0;
      r_stage_cnt <= '0;
      r_rd_idx    <= '0;
      r_cnt       <= '0;
      r_acc_vld   <= 1'b0;
      r_acc_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_func      <= cmd_func;
            r_in_len    <= w_in_len;
            r_out_len   <= w_out_len;
            r_wait      <= cmd_wait;
            r_stage_cnt <= '0;
            if (w_in_len != '0) begin
              r_state <= S_PRELOAD;
            end else begin
              r_state <= w_post_cmd;
              r_cnt   <= phase_cnt(cmd_wait, w_out_len);
              r_done  <= (w_post_cmd == S_IDLE);
            end
          end
        end
        S_PRELOAD: begin
          if (w_s_fire) begin
            r_stage_cnt <= r_stage_cnt + CW'(1);
            if (r_stage_cnt + CW'(1) == r_in_len) begin
              // The word arriving now is slot 0 only for a one-word burst; bypass it.
              r_state    <= S_SEND;
              r_acc_vld  <= 1'b1;
              r_acc_data <= (r_stage_cnt == '0) ? s_data : r_stage[0];
              r_rd_idx   <= CW'(1);
            end
          end
        end
        S_SEND: begin
          if (r_rd_idx == r_in_len) begin
            r_acc_vld  <= 1'b0;
            r_acc_data <= '0;
            r_state    <= w_post_send;
            r_cnt      <= phase_cnt(r_wait, r_out_len);
            r_done     <= (w_post_send == S_IDLE);
          end else begin
            r_acc_data <= r_stage[r_rd_idx[PW-1:0]];
            r_rd_idx   <= r_rd_idx + CW'(1);
          end
        end
        S_WAIT: begin
          if (r_cnt == 8'd1) begin
            if (r_out_len != '0) begin
              r_state <= S_CAPTURE;
              r_cnt   <= 8'(r_out_len);
            end else begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_CAPTURE: begin
          if (r_cnt == 8'd1) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_s_fire) r_stage[r_stage_cnt[PW-1:0]] <= s_data;
  end

  // Result FIFO: storage is unreset; emptiness is carried entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= acc_out_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
